// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen -- stall/flush controller for an N-stage pipeline.
//   Freezes every stage upstream of the highest stall requester. Sequences
//   exception and ERET redirects: freeze, then a one-cycle registered flush
//   carrying new_pc, then a refill cycle. Also keeps a saturating count of
//   stalled cycles and a sticky watchdog for long continuous stalls.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   stallreq         per-stage stall requests (bit 0 unused)
//   excp_req         exception taken; wins over eret_req
//   eret_req/epc_in  ERET commit and its return address
//   wdog_clr         clears the watchdog flag and its counter
//   stall            stall vector, bit 0 = PC hold, bit i = stage i hold
//   flush/new_pc     registered flush pulse and redirect target (0 otherwise)
//   stall_cycles     saturating count of cycles with stall != 0
//   wdog_timeout     sticky watchdog flag
module pipe_ctrl_gen #(
  parameter int                 NUM_STAGES = 6,
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR = 'h20,
  parameter int                 WDOG_LIMIT = 1024,
  parameter int                 CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  excp_req,
  input  logic                  eret_req,
  input  logic [ADDR_W-1:0]     epc_in,
  input  logic                  wdog_clr,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [ADDR_W-1:0]     new_pc,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  wdog_timeout
);

  localparam int WCW = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FREEZE, FLUSH, REFILL} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_lat_q, pc_lat_d;
  logic                  flush_q;
  logic [ADDR_W-1:0]     new_pc_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  wdog_q, wdog_d;
  logic [NUM_STAGES-1:0] rule, stall_c;
  logic                  stall_nz, wd_en;

  // Stage i holds if any stage at or below it in the pipe (index >= i) asks;
  // the PC holds whenever anything asks.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    rule = '0;
    for (int i = NUM_STAGES - 1; i >= 1; i--) begin
      acc     = acc | stallreq[i];
      rule[i] = acc;
    end
    rule[0] = acc;
  end

  always_comb begin
    state_d  = state_q;
    pc_lat_d = pc_lat_q;
    stall_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (excp_req) begin
          stall_c  = '1;
          pc_lat_d = EXC_VECTOR;
          state_d  = FREEZE;
        end else if (eret_req) begin
          stall_c  = '1;
          pc_lat_d = epc_in;
          state_d  = FREEZE;
        end else begin
          stall_c  = rule;
        end
      end
      FREEZE: begin
        stall_c = '1;
        state_d = FLUSH;
      end
      FLUSH:   state_d = REFILL;
      // Redirect requests are ignored here: no nested redirect.
      REFILL: begin
        stall_c = rule;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_nz = |stall_c;
  // The watchdog only times stalls the pipeline asked for, not redirect freezes.
  assign wd_en    = stall_nz && (state_q == IDLE || state_q == REFILL);

  always_comb begin
    cnt_d = cnt_q;
    if (stall_nz && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;

    wcnt_d = wcnt_q;
    if (wdog_clr || !stall_nz)                   wcnt_d = '0;
    else if (wd_en && wcnt_q < WCW'(WDOG_LIMIT)) wcnt_d = wcnt_q + 1'b1;

    // Flag rises on the edge where the counter reaches the limit; clear wins.
    wdog_d = wdog_clr ? 1'b0
                      : (wdog_q | (wd_en && wcnt_q >= WCW'(WDOG_LIMIT - 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_lat_q <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      wdog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_lat_q <= pc_lat_d;
      flush_q  <= (state_q == FREEZE);
      new_pc_q <= (state_q == FREEZE) ? pc_lat_q : '0;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      wdog_q   <= wdog_d;
    end
  end

  // Stall is combinational, so it is gated by reset to drop immediately.
  assign stall        = rst ? '0 : stall_c;
  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign stall_cycles = cnt_q;
  assign wdog_timeout = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
module tb_pipe_ctrl_gen;
  localparam int N = 6;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  stallreq = '0;
  logic          excp_req = 1'b0;
  logic          eret_req = 1'b0;
  logic [AW-1:0] epc_in = '0;
  logic          wdog_clr = 1'b0;
  logic [N-1:0]  stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic [CW-1:0] stall_cycles;
  logic          wdog_timeout;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_gen #(
    .NUM_STAGES(N), .ADDR_W(AW), .EXC_VECTOR(32'h0000_0020),
    .WDOG_LIMIT(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .excp_req(excp_req),
    .eret_req(eret_req), .epc_in(epc_in), .wdog_clr(wdog_clr),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Redirect expectations: flush low, flush high with pc, flush low again.
  task automatic chk_idle_outs(input string tag);
    chk({tag, " flush"}, 64'(flush), 64'd0);
    chk({tag, " new_pc"}, 64'(new_pc), 64'd0);
  endtask

  initial begin
    // ---- reset state ----
    #2;
    chk("rst stall", 64'(stall), 64'd0);
    chk_idle_outs("rst");
    chk("rst cnt", 64'(stall_cycles), 64'd0);
    chk("rst wdog", 64'(wdog_timeout), 64'd0);
    step(); step();
    rst = 1'b0;

    // ---- async reset mid-cycle while stalling ----
    stallreq = 6'b001000;
    step(); step(); step();
    chk("pre-rst cnt", 64'(stall_cycles), 64'd3);
    #3 rst = 1'b1;
    #1;
    chk("async rst stall", 64'(stall), 64'd0);
    chk("async rst cnt", 64'(stall_cycles), 64'd0);
    chk_idle_outs("async rst");
    chk("async rst wdog", 64'(wdog_timeout), 64'd0);
    stallreq = '0;
    step();
    rst = 1'b0;

    // ---- stall decode (combinational, no edges) ----
    stallreq = 6'b000100; #1 chk("dec s2", 64'(stall), 64'b000111);
    stallreq = 6'b001000; #1 chk("dec s3", 64'(stall), 64'b001111);
    stallreq = 6'b001100; #1 chk("dec s2+3", 64'(stall), 64'b001111);
    stallreq = 6'b000001; #1 chk("dec bit0", 64'(stall), 64'b000000);
    stallreq = 6'b100000; #1 chk("dec s5", 64'(stall), 64'b111111);
    stallreq = 6'b000010; #1 chk("dec s1", 64'(stall), 64'b000011);
    chk("dec cnt", 64'(stall_cycles), 64'd0);
    stallreq = 6'b001000;
    repeat (5) step();
    chk("cnt 5", 64'(stall_cycles), 64'd5);
    stallreq = '0;
    step();
    chk("cnt hold", 64'(stall_cycles), 64'd5);

    // ---- exception, held high T..T+3, new one at T+4 ----
    rst = 1'b1; #1 rst = 1'b0;
    step();
    excp_req = 1'b1;                   // T
    #1 chk("exc T stall", 64'(stall), 64'h3f);
    chk_idle_outs("exc T");
    step();                            // T+1
    chk("exc T1 stall", 64'(stall), 64'h3f);
    chk_idle_outs("exc T1");
    step();                            // T+2
    chk("exc T2 flush", 64'(flush), 64'd1);
    chk("exc T2 pc", 64'(new_pc), 64'h20);
    chk("exc T2 stall", 64'(stall), 64'd0);
    step();                            // T+3 (REFILL, excp ignored)
    chk_idle_outs("exc T3");
    chk("exc T3 stall", 64'(stall), 64'd0);
    step();                            // T+4 new request accepted
    chk("exc T4 stall", 64'(stall), 64'h3f);
    chk_idle_outs("exc T4");
    step();                            // T+5
    excp_req = 1'b0;
    #1 chk("exc T5 stall", 64'(stall), 64'h3f);
    chk_idle_outs("exc T5");
    step();                            // T+6
    chk("exc T6 flush", 64'(flush), 64'd1);
    chk("exc T6 pc", 64'(new_pc), 64'h20);
    step();                            // T+7
    chk_idle_outs("exc T7");
    chk("exc cnt", 64'(stall_cycles), 64'd4);
    step();                            // back in IDLE

    // ---- exception beats ERET, then ERET alone ----
    excp_req = 1'b1; eret_req = 1'b1; epc_in = 32'h8000_0100;
    step();
    excp_req = 1'b0; eret_req = 1'b0; epc_in = '0;
    step();
    chk("prio flush", 64'(flush), 64'd1);
    chk("prio pc", 64'(new_pc), 64'h20);
    step(); step();
    eret_req = 1'b1; epc_in = 32'h8000_0100;
    step();
    eret_req = 1'b0; epc_in = '0;
    step();
    chk("eret flush", 64'(flush), 64'd1);
    chk("eret pc", 64'(new_pc), 64'h8000_0100);
    step();
    chk_idle_outs("eret after");

    // ---- reset in FREEZE aborts the flush ----
    step();
    excp_req = 1'b1;
    step();                            // now in FREEZE
    excp_req = 1'b0;
    #3 rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outs("abort a");
    step();
    chk_idle_outs("abort b");
    step();
    chk_idle_outs("abort c");

    // ---- watchdog: 8 consecutive stalled cycles ----
    rst = 1'b1; #1 rst = 1'b0;
    stallreq = 6'b001000;
    repeat (7) step();
    chk("wd 7", 64'(wdog_timeout), 64'd0);
    step();
    chk("wd 8", 64'(wdog_timeout), 64'd1);
    stallreq = '0;
    step(); step();
    chk("wd sticky", 64'(wdog_timeout), 64'd1);
    wdog_clr = 1'b1;
    step();
    wdog_clr = 1'b0;
    chk("wd clr", 64'(wdog_timeout), 64'd0);
    // 7 stalled, 1 free, 7 stalled: no timeout
    stallreq = 6'b001000;
    repeat (7) step();
    stallreq = '0;
    step();
    stallreq = 6'b001000;
    repeat (7) step();
    chk("wd gap", 64'(wdog_timeout), 64'd0);
    // 8th stalled edge coincides with clear: clear wins
    wdog_clr = 1'b1;
    step();
    wdog_clr = 1'b0;
    chk("wd clr wins", 64'(wdog_timeout), 64'd0);
    step();
    chk("wd cnt cleared", 64'(wdog_timeout), 64'd0);
    stallreq = '0;
    step();

    // ---- stall counter saturation ----
    rst = 1'b1; #1 rst = 1'b0;
    stallreq = 6'b000100;
    repeat (14) step();
    chk("cnt 14", 64'(stall_cycles), 64'd14);
    repeat (6) step();
    chk("cnt sat", 64'(stall_cycles), 64'd15);
    stallreq = '0;
    step();
    chk("cnt sat hold", 64'(stall_cycles), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
